// File: rtl/exception_controller.sv
// Exception/interrupt entry sequencer for cpu32e2: prioritises 3 faults + 16 IRQs, then saves PC, clears IE, presents vector.
// Latency: acceptance -> PENDING, then one cycle after instrBoundary -> ENTER (1 cycle) -> VECTOR; vectorValid held until vectorTaken.
// Backpressure: waits indefinitely on instrBoundary (PENDING) and vectorTaken (VECTOR); faults arriving meanwhile are latched.
//
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   irq[15:0], exceptionMask   - level interrupts and per-line enables (bit i -> cause i)
//   interruptEnable            - global interrupt enable
//   isrBaseAddress[31:0]       - vector base
//   illegalInstr, systemCallReq, alignFault - single-cycle fault pulses
//   instrBoundary, vectorTaken - core handshakes
//   exceptionPending           - suppresses architectural writes
//   cause[4:0]                 - current/last cause code
//   savePc, clearInterruptEnable - one-cycle strobes during entry
//   vectorValid, vectorAddress - handler vector = isrBaseAddress + (cause << 2)
module exception_controller #(
  parameter int         IRQ_COUNT     = 16,
  parameter logic [4:0] CAUSE_ILLEGAL = 5'd16,
  parameter logic [4:0] CAUSE_SYSCALL = 5'd17,
  parameter logic [4:0] CAUSE_ALIGN   = 5'd18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] irq,
  input  logic [15:0] exceptionMask,
  input  logic        interruptEnable,
  input  logic [31:0] isrBaseAddress,
  input  logic        illegalInstr,
  input  logic        systemCallReq,
  input  logic        alignFault,
  input  logic        instrBoundary,
  input  logic        vectorTaken,
  output logic        exceptionPending,
  output logic [4:0]  cause,
  output logic        savePc,
  output logic        clearInterruptEnable,
  output logic        vectorValid,
  output logic [31:0] vectorAddress
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ENTER   = 2'd2,
    ST_VECTOR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  fault_latch_q, fault_latch_d;  // {align, syscall, illegal}
  logic [4:0]  cause_q, cause_d;
  logic        pend_q, pend_d;
  logic        save_pc_q, save_pc_d;
  logic        vec_vld_q, vec_vld_d;

  logic [2:0]  fault_pulse;
  logic [2:0]  fault_req;
  logic [2:0]  fault_clr;
  logic [15:0] irq_act;
  logic        irq_req;
  logic [4:0]  irq_cause;

  always_comb begin
    fault_pulse = {alignFault, systemCallReq, illegalInstr};
    fault_req   = fault_latch_q | fault_pulse;
    irq_act     = irq & exceptionMask;
    irq_req     = interruptEnable & (|irq_act);

    // Scan from the top so the lowest set index is the one left standing.
    irq_cause = 5'd0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (irq_act[i]) irq_cause = 5'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    fault_clr = 3'b000;

    case (state_q)
      ST_IDLE: begin
        if (|fault_req) begin
          if (fault_req[0]) begin
            cause_d   = CAUSE_ILLEGAL;
            fault_clr = 3'b001;
          end else if (fault_req[1]) begin
            cause_d   = CAUSE_SYSCALL;
            fault_clr = 3'b010;
          end else begin
            cause_d   = CAUSE_ALIGN;
            fault_clr = 3'b100;
          end
          state_d = ST_PENDING;
        end else if (irq_req) begin
          cause_d = irq_cause;
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (instrBoundary) state_d = ST_ENTER;
      end
      ST_ENTER: begin
        state_d = ST_VECTOR;
      end
      ST_VECTOR: begin
        if (vectorTaken) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A pulse that is itself the fault being accepted is consumed here. If the
    // bit was already latched, the new pulse is a second event and stays set.
    fault_latch_d = (fault_latch_q & ~fault_clr)
                  | (fault_pulse & (fault_latch_q | ~fault_clr));

    // Outputs are registered off the next state so they line up with it.
    pend_d    = (state_d != ST_IDLE);
    save_pc_d = (state_d == ST_ENTER);
    vec_vld_d = (state_d == ST_VECTOR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      fault_latch_q <= 3'b000;
      cause_q       <= 5'd0;
      pend_q        <= 1'b0;
      save_pc_q     <= 1'b0;
      vec_vld_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fault_latch_q <= fault_latch_d;
      cause_q       <= cause_d;
      pend_q        <= pend_d;
      save_pc_q     <= save_pc_d;
      vec_vld_q     <= vec_vld_d;
    end
  end

  // Faults must block a system-register write in the very cycle they arrive,
  // so they bypass the register in IDLE. Interrupts only take effect next cycle.
  assign exceptionPending     = pend_q | ((state_q == ST_IDLE) & (|fault_req));
  assign cause                = cause_q;
  assign savePc               = save_pc_q;
  assign clearInterruptEnable = save_pc_q;
  assign vectorValid          = vec_vld_q;
  assign vectorAddress        = isrBaseAddress + {25'd0, cause_q, 2'b00};

endmodule

// File: tb/tb_exception_controller.sv
module tb_exception_controller;

  logic        clk;
  logic        reset;
  logic [15:0] irq;
  logic [15:0] exceptionMask;
  logic        interruptEnable;
  logic [31:0] isrBaseAddress;
  logic        illegalInstr;
  logic        systemCallReq;
  logic        alignFault;
  logic        instrBoundary;
  logic        vectorTaken;
  logic        exceptionPending;
  logic [4:0]  cause;
  logic        savePc;
  logic        clearInterruptEnable;
  logic        vectorValid;
  logic [31:0] vectorAddress;

  int checks;
  int failures;

  exception_controller dut (
    .clk                  (clk),
    .reset                (reset),
    .irq                  (irq),
    .exceptionMask        (exceptionMask),
    .interruptEnable      (interruptEnable),
    .isrBaseAddress       (isrBaseAddress),
    .illegalInstr         (illegalInstr),
    .systemCallReq        (systemCallReq),
    .alignFault           (alignFault),
    .instrBoundary        (instrBoundary),
    .vectorTaken          (vectorTaken),
    .exceptionPending     (exceptionPending),
    .cause                (cause),
    .savePc               (savePc),
    .clearInterruptEnable (clearInterruptEnable),
    .vectorValid          (vectorValid),
    .vectorAddress        (vectorAddress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 = idle, 1 = waiting for boundary,
  // 2 = entry strobe cycle, 3 = vector offered.
  int         m_phase;
  logic [2:0] m_pend;   // outstanding faults {align, syscall, illegal}
  logic [4:0] m_cause;

  task automatic model_reset();
    m_phase = 0;
    m_pend  = 3'b000;
    m_cause = 5'd0;
  endtask

  task automatic model_step();
    logic [2:0]  p;
    logic [2:0]  req;
    logic [15:0] act;
    logic        stacked;
    int          k;
    p   = {alignFault, systemCallReq, illegalInstr};
    act = irq & exceptionMask;
    if (m_phase == 0) begin
      req = m_pend | p;
      if (req != 3'b000) begin
        k = req[0] ? 0 : (req[1] ? 1 : 2);
        m_cause = 5'(16 + k);
        stacked = m_pend[k] & p[k];
        m_pend  = m_pend | p;
        if (!stacked) m_pend[k] = 1'b0;
        m_phase = 1;
      end else if (interruptEnable && act != 16'h0) begin
        for (int j = 0; j < 16; j++) begin
          if (act[j]) begin
            m_cause = 5'(j);
            break;
          end
        end
        m_phase = 1;
      end
    end else begin
      m_pend = m_pend | p;
      if (m_phase == 1) begin
        if (instrBoundary) m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 3;
      end else if (vectorTaken) begin
        m_phase = 0;
      end
    end
  endtask

  function automatic logic exp_pending();
    logic [2:0] p;
    p = {alignFault, systemCallReq, illegalInstr};
    return (m_phase != 0) || ((m_pend | p) != 3'b000);
  endfunction

  function automatic logic [31:0] exp_vaddr();
    return isrBaseAddress + 32'(m_cause) * 32'd4;
  endfunction

  // Advance one clock: update the model from the inputs of the ending cycle,
  // then return 1 time unit after the rising edge for new stimulus.
  task automatic tick();
    if (reset) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    irq             = 16'h0;
    exceptionMask   = 16'h0;
    interruptEnable = 1'b0;
    illegalInstr    = 1'b0;
    systemCallReq   = 1'b0;
    alignFault      = 1'b0;
    instrBoundary   = 1'b0;
    vectorTaken     = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    isrBaseAddress = 32'h0000_1000;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (exceptionPending !== 1'b0) begin failures++; $display("FAIL rst_pending got=%0b exp=0", exceptionPending); end
    checks++; if (cause !== 5'd0) begin failures++; $display("FAIL rst_cause got=%0d exp=0", cause); end
    checks++; if (savePc !== 1'b0 || clearInterruptEnable !== 1'b0) begin failures++; $display("FAIL rst_strobes got=%0b%0b exp=00", savePc, clearInterruptEnable); end
    checks++; if (vectorValid !== 1'b0) begin failures++; $display("FAIL rst_vvalid got=%0b exp=0", vectorValid); end
    checks++; if (vectorAddress !== 32'h0000_1000) begin failures++; $display("FAIL rst_vaddr got=%h exp=00001000", vectorAddress); end
    tick();
  endtask

  task automatic test_illegal();
    isrBaseAddress = 32'h0000_1000;
    instrBoundary  = 1'b1;
    illegalInstr   = 1'b1;
    @(negedge clk);
    checks++; if (exceptionPending !== 1'b1) begin failures++; $display("FAIL ill_pend_same_cycle got=%0b exp=1", exceptionPending); end
    tick();
    illegalInstr = 1'b0;
    @(negedge clk);
    checks++; if (cause !== 5'd16) begin failures++; $display("FAIL ill_cause got=%0d exp=16", cause); end
    checks++; if (savePc !== 1'b0) begin failures++; $display("FAIL ill_savepc_early got=%0b exp=0", savePc); end
    tick();
    @(negedge clk);
    checks++; if (savePc !== 1'b1 || clearInterruptEnable !== 1'b1) begin failures++; $display("FAIL ill_enter_strobes got=%0b%0b exp=11", savePc, clearInterruptEnable); end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (vectorValid !== 1'b1 || vectorAddress !== 32'h0000_1040) begin failures++; $display("FAIL ill_vector got=%0b/%h exp=1/00001040", vectorValid, vectorAddress); end
      checks++; if (savePc !== 1'b0) begin failures++; $display("FAIL ill_savepc_one_cycle got=%0b exp=0", savePc); end
      tick();
    end
    vectorTaken = 1'b1;
    @(negedge clk);
    checks++; if (vectorValid !== 1'b1) begin failures++; $display("FAIL ill_vv_on_taken got=%0b exp=1", vectorValid); end
    tick();
    vectorTaken   = 1'b0;
    instrBoundary = 1'b0;
    @(negedge clk);
    checks++; if (vectorValid !== 1'b0 || exceptionPending !== 1'b0) begin failures++; $display("FAIL ill_return got=%0b/%0b exp=0/0", vectorValid, exceptionPending); end
    checks++; if (cause !== 5'd16) begin failures++; $display("FAIL ill_cause_held got=%0d exp=16", cause); end
    tick();
  endtask

  task automatic test_irq();
    isrBaseAddress  = 32'h0000_1000;
    interruptEnable = 1'b1;
    exceptionMask   = 16'h0028;
    irq             = 16'h00FF;
    instrBoundary   = 1'b1;
    @(negedge clk);
    checks++; if (exceptionPending !== 1'b0) begin failures++; $display("FAIL irq_not_comb got=%0b exp=0", exceptionPending); end
    tick();
    // Retracting the request must not cancel the accepted entry.
    irq           = 16'h0;
    exceptionMask = 16'h0;
    @(negedge clk);
    checks++; if (cause !== 5'd3 || exceptionPending !== 1'b1) begin failures++; $display("FAIL irq_cause got=%0d/%0b exp=3/1", cause, exceptionPending); end
    tick();
    tick();
    @(negedge clk);
    checks++; if (vectorValid !== 1'b1 || vectorAddress !== 32'h0000_100C) begin failures++; $display("FAIL irq_vector got=%0b/%h exp=1/0000100c", vectorValid, vectorAddress); end
    vectorTaken = 1'b1;
    tick();
    vectorTaken     = 1'b0;
    interruptEnable = 1'b0;
    exceptionMask   = 16'h0028;
    irq             = 16'h00FF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (exceptionPending !== 1'b0 || vectorValid !== 1'b0) begin failures++; $display("FAIL irq_disabled got=%0b/%0b exp=0/0", exceptionPending, vectorValid); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_fault_vs_irq();
    isrBaseAddress  = 32'h0000_1000;
    interruptEnable = 1'b1;
    exceptionMask   = 16'hFFFF;
    irq             = 16'h0004;
    systemCallReq   = 1'b1;
    instrBoundary   = 1'b1;
    @(negedge clk);
    checks++; if (exceptionPending !== 1'b1) begin failures++; $display("FAIL fvi_pend got=%0b exp=1", exceptionPending); end
    tick();
    systemCallReq = 1'b0;
    @(negedge clk);
    checks++; if (cause !== 5'd17) begin failures++; $display("FAIL fvi_cause got=%0d exp=17", cause); end
    tick();
    @(negedge clk);
    // System block reacts to the strobe by dropping the global enable.
    if (clearInterruptEnable) interruptEnable = 1'b0;
    tick();
    vectorTaken = 1'b1;
    @(negedge clk);
    checks++; if (vectorAddress !== 32'h0000_1044) begin failures++; $display("FAIL fvi_vaddr got=%h exp=00001044", vectorAddress); end
    tick();
    vectorTaken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (exceptionPending !== 1'b0 || cause !== 5'd17) begin failures++; $display("FAIL fvi_irq_masked got=%0b/%0d exp=0/17", exceptionPending, cause); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    isrBaseAddress = 32'h0000_2000;
    instrBoundary  = 1'b1;
    illegalInstr   = 1'b1;
    tick();
    illegalInstr = 1'b0;
    tick();
    tick();
    alignFault = 1'b1;   // arrives while the vector is being offered
    @(negedge clk);
    checks++; if (vectorValid !== 1'b1 || cause !== 5'd16) begin failures++; $display("FAIL b2b_first got=%0b/%0d exp=1/16", vectorValid, cause); end
    tick();
    alignFault  = 1'b0;
    vectorTaken = 1'b1;
    tick();
    vectorTaken = 1'b0;
    @(negedge clk);
    checks++; if (exceptionPending !== 1'b1 || vectorValid !== 1'b0) begin failures++; $display("FAIL b2b_no_gap got=%0b/%0b exp=1/0", exceptionPending, vectorValid); end
    tick();
    @(negedge clk);
    checks++; if (cause !== 5'd18 || exceptionPending !== 1'b1) begin failures++; $display("FAIL b2b_cause got=%0d/%0b exp=18/1", cause, exceptionPending); end
    tick();
    tick();
    @(negedge clk);
    checks++; if (vectorValid !== 1'b1 || vectorAddress !== 32'h0000_2048) begin failures++; $display("FAIL b2b_vector got=%0b/%h exp=1/00002048", vectorValid, vectorAddress); end
    vectorTaken = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_midwait();
    isrBaseAddress = 32'h0000_3000;
    instrBoundary  = 1'b0;
    illegalInstr   = 1'b1;
    tick();
    illegalInstr  = 1'b0;
    systemCallReq = 1'b1;  // latched behind the active entry
    tick();
    systemCallReq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (exceptionPending !== 1'b1 || vectorValid !== 1'b0) begin failures++; $display("FAIL mid_wait got=%0b/%0b exp=1/0", exceptionPending, vectorValid); end
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (exceptionPending !== 1'b0 || cause !== 5'd0 || savePc !== 1'b0 || vectorValid !== 1'b0) begin failures++; $display("FAIL mid_reset got=%0b/%0d/%0b/%0b exp=0/0/0/0", exceptionPending, cause, savePc, vectorValid); end
    checks++; if (vectorAddress !== 32'h0000_3000) begin failures++; $display("FAIL mid_reset_vaddr got=%h exp=00003000", vectorAddress); end
    tick();
    reset         = 1'b0;
    instrBoundary = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (exceptionPending !== 1'b0 || cause !== 5'd0) begin failures++; $display("FAIL mid_latch_discarded got=%0b/%0d exp=0/0", exceptionPending, cause); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    isrBaseAddress = 32'hFFFF_FFF0;
    instrBoundary  = 1'b1;
    systemCallReq  = 1'b1;
    tick();
    systemCallReq = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++; if (vectorValid !== 1'b1 || vectorAddress !== 32'h0000_0034) begin failures++; $display("FAIL wrap_vaddr got=%0b/%h exp=1/00000034", vectorValid, vectorAddress); end
    vectorTaken = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      irq             = 16'($urandom);
      exceptionMask   = 16'($urandom);
      interruptEnable = ($urandom_range(0, 3) == 0);
      isrBaseAddress  = $urandom;
      illegalInstr    = ($urandom_range(0, 15) == 0);
      systemCallReq   = ($urandom_range(0, 15) == 0);
      alignFault      = ($urandom_range(0, 15) == 0);
      instrBoundary   = ($urandom_range(0, 1) == 0);
      vectorTaken     = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      checks++; if (exceptionPending !== exp_pending()) begin failures++; $display("FAIL rnd_pending n=%0d got=%0b exp=%0b", n, exceptionPending, exp_pending()); end
      checks++; if (cause !== m_cause) begin failures++; $display("FAIL rnd_cause n=%0d got=%0d exp=%0d", n, cause, m_cause); end
      checks++; if (savePc !== (m_phase == 2)) begin failures++; $display("FAIL rnd_savepc n=%0d got=%0b exp=%0b", n, savePc, (m_phase == 2)); end
      checks++; if (clearInterruptEnable !== (m_phase == 2)) begin failures++; $display("FAIL rnd_clrie n=%0d got=%0b exp=%0b", n, clearInterruptEnable, (m_phase == 2)); end
      checks++; if (vectorValid !== (m_phase == 3)) begin failures++; $display("FAIL rnd_vvalid n=%0d got=%0b exp=%0b", n, vectorValid, (m_phase == 3)); end
      checks++; if (vectorAddress !== exp_vaddr()) begin failures++; $display("FAIL rnd_vaddr n=%0d got=%h exp=%h", n, vectorAddress, exp_vaddr()); end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    isrBaseAddress = 32'h0;
    clear_inputs();
    test_reset();
    test_illegal();
    test_irq();
    test_fault_vs_irq();
    test_back_to_back();
    test_reset_midwait();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
